// File: rtl/queue_cntrl_mc_pkg.sv
// Shared types and helpers for the multi-channel queue controller.
// Width helpers, per-channel state struct, and wrap-around pointer increment.
package q_queue_pkg;

   // Storage width for per-channel state fields; upper bits stay zero.
   localparam int ST_W = 16;

   function automatic int ch_w(input int c);
      return (c > 1) ? $clog2(c) : 1;
   endfunction

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int addr_w(input int c, input int n);
      return (c * n > 1) ? $clog2(c * n) : 1;
   endfunction

   typedef struct packed {
      logic [ST_W-1:0] wr_ptr;
      logic [ST_W-1:0] rd_ptr;
      logic [ST_W-1:0] cnt;
   } ch_state_t;

   // Wraps at n-1, not at a power-of-two boundary.
   function automatic logic [ST_W-1:0] ptr_inc(
      input logic [ST_W-1:0] ptr,
      input int              n
   );
      return (ptr == ST_W'(n - 1)) ? '0 : ptr + ST_W'(1);
   endfunction

endpackage

// File: rtl/queue_cntrl_ch.sv
// One logical queue: pointers, occupancy, registered status, optional error flags.
// In: i_push/i_pop/i_flush already decoded for this channel.
// Out: accept strobes, pointers, count, full/empty/afull.
// Error flags o_err_ovf/o_err_udf exist only with QUEUE_CNTRL_MC_ERR_EN.
module queue_cntrl_ch
   import q_queue_pkg::*;
#(
   parameter  int N            = 6,
   parameter  int AFULL_THRESH = N - 1,
   localparam int PTR_W        = ptr_w(N),
   localparam int CNT_W        = cnt_w(N)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic             o_wr_ok,
   output logic             o_rd_ok,
   output logic [PTR_W-1:0] o_wr_ptr,
   output logic [PTR_W-1:0] o_rd_ptr,
   output logic [CNT_W-1:0] o_cnt,
`ifdef QUEUE_CNTRL_MC_ERR_EN
   output logic             o_err_ovf,
   output logic             o_err_udf,
`endif
   output logic             o_full,
   output logic             o_empty,
   output logic             o_afull
);

   ch_state_t st_q, st_d;
   logic      full_q, empty_q, afull_q;
   logic      wr_ok, rd_ok;

   // Acceptance uses registered status: no full-bypass on pop,
   // no empty-bypass on push.
   assign wr_ok = i_push & ~full_q & ~i_flush;
   assign rd_ok = i_pop & ~empty_q & ~i_flush;

   always_comb begin
      st_d = st_q;
      if (i_flush) begin
         st_d = '0;
      end else begin
         if (wr_ok) st_d.wr_ptr = ptr_inc(st_q.wr_ptr, N);
         if (rd_ok) st_d.rd_ptr = ptr_inc(st_q.rd_ptr, N);
         if (wr_ok && !rd_ok)
            st_d.cnt = st_q.cnt + ST_W'(1);
         else if (rd_ok && !wr_ok)
            st_d.cnt = st_q.cnt - ST_W'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         st_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         afull_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         full_q  <= (st_d.cnt == ST_W'(N));
         empty_q <= (st_d.cnt == '0);
         afull_q <= (st_d.cnt >= ST_W'(AFULL_THRESH));
      end
   end

`ifdef QUEUE_CNTRL_MC_ERR_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else if (i_flush) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (i_push & full_q);
         udf_q <= udf_q | (i_pop & empty_q);
      end
   end

   assign o_err_ovf = ovf_q;
   assign o_err_udf = udf_q;
`endif

   assign o_wr_ok  = wr_ok;
   assign o_rd_ok  = rd_ok;
   assign o_wr_ptr = st_q.wr_ptr[PTR_W-1:0];
   assign o_rd_ptr = st_q.rd_ptr[PTR_W-1:0];
   assign o_cnt    = st_q.cnt[CNT_W-1:0];
   assign o_full   = full_q;
   assign o_empty  = empty_q;
   assign o_afull  = afull_q;

endmodule

// File: rtl/queue_cntrl_mc.sv
// C logical FIFOs of depth N sharing one C*N-entry RAM; emits RAM enables/addresses.
// In: push/pop/flush requests with channel; Out: wr/rd enable+address, per-ch status.
// QUEUE_CNTRL_MC_ERR_EN adds sticky o_err_ovf/o_err_udf per channel.
module queue_cntrl_mc
   import q_queue_pkg::*;
#(
   parameter  int C            = 4,
   parameter  int N            = 6,
   parameter  int AFULL_THRESH = N - 1,
   localparam int CH_W         = ch_w(C),
   localparam int PTR_W        = ptr_w(N),
   localparam int CNT_W        = cnt_w(N),
   localparam int ADDR_W       = addr_w(C, N)
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               i_push,
   input  logic [CH_W-1:0]    i_push_ch,
   input  logic               i_pop,
   input  logic [CH_W-1:0]    i_pop_ch,
   input  logic               i_flush,
   input  logic [CH_W-1:0]    i_flush_ch,
   output logic               o_wr_en,
   output logic [ADDR_W-1:0]  o_wr_addr,
   output logic               o_rd_en,
   output logic [ADDR_W-1:0]  o_rd_addr,
   output logic [C-1:0]       o_full,
   output logic [C-1:0]       o_empty,
   output logic [C-1:0]       o_afull,
`ifdef QUEUE_CNTRL_MC_ERR_EN
   output logic [C-1:0]       o_err_ovf,
   output logic [C-1:0]       o_err_udf,
`endif
   output logic [C*CNT_W-1:0] o_cnt
);

   logic [C-1:0]     wr_ok, rd_ok;
   logic [PTR_W-1:0] wr_ptr [C];
   logic [PTR_W-1:0] rd_ptr [C];
   logic [PTR_W-1:0] wsel, rsel;

   for (genvar g = 0; g < C; g++) begin : g_ch
      logic [CNT_W-1:0] cnt;

      queue_cntrl_ch #(
         .N            (N),
         .AFULL_THRESH (AFULL_THRESH)
      ) u_ch (
         .clk       (clk),
         .arst      (arst),
         .i_push    (i_push  & (i_push_ch  == CH_W'(g))),
         .i_pop     (i_pop   & (i_pop_ch   == CH_W'(g))),
         .i_flush   (i_flush & (i_flush_ch == CH_W'(g))),
         .o_wr_ok   (wr_ok[g]),
         .o_rd_ok   (rd_ok[g]),
         .o_wr_ptr  (wr_ptr[g]),
         .o_rd_ptr  (rd_ptr[g]),
         .o_cnt     (cnt),
`ifdef QUEUE_CNTRL_MC_ERR_EN
         .o_err_ovf (o_err_ovf[g]),
         .o_err_udf (o_err_udf[g]),
`endif
         .o_full    (o_full[g]),
         .o_empty   (o_empty[g]),
         .o_afull   (o_afull[g])
      );

      assign o_cnt[g*CNT_W +: CNT_W] = cnt;
   end

   // Loop mux tolerates channel codes >= C when C is not a power of two.
   always_comb begin
      wsel = '0;
      rsel = '0;
      for (int c = 0; c < C; c++) begin
         if (i_push_ch == CH_W'(c)) wsel = wr_ptr[c];
         if (i_pop_ch  == CH_W'(c)) rsel = rd_ptr[c];
      end
   end

   assign o_wr_en   = |wr_ok;
   assign o_rd_en   = |rd_ok;
   assign o_wr_addr = ADDR_W'(i_push_ch) * ADDR_W'(N) + ADDR_W'(wsel);
   assign o_rd_addr = ADDR_W'(i_pop_ch)  * ADDR_W'(N) + ADDR_W'(rsel);

endmodule
